// File: rtl/serdes_pkg.sv
// Shared definitions for the wide serial link: receive FSM states, packet
// count derivation and start-packet field positions.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } depkt_state_e;

  // Start packet fields
  localparam int unsigned START_VALID_BIT = 0;
  localparam int unsigned START_ID_BIT    = 1;

  // Number of data packets carrying one payload
  function automatic int unsigned calc_n_data(input int unsigned payload_width,
                                              input int unsigned packet_width);
    return payload_width / packet_width;
  endfunction

  // Header value: data packets plus the header itself
  function automatic int unsigned calc_n_pkts(input int unsigned payload_width,
                                              input int unsigned packet_width);
    return calc_n_data(payload_width, packet_width) + 1;
  endfunction

endpackage

// File: rtl/depacketizer_wide_if.sv
// Link-side and consumer-side signals of the wide depacketizer.
//   slave  : receiver view (depacketizer_wide)
//   master : sender / consumer view
// Ports: packet_req_i, lock_i, packet_i, packet_grant_o, packet_received_o,
//        payload_o, payload_valid_o, payload_ready_i, error_o.
interface depacketizer_wide_if #(
  parameter int unsigned PAYLOAD_WIDTH = 512,
  parameter int unsigned PACKET_WIDTH  = 16
);

  logic                     packet_req_i;
  logic                     lock_i;
  logic [PACKET_WIDTH-1:0]  packet_i;
  logic                     packet_grant_o;
  logic                     packet_received_o;
  logic [PAYLOAD_WIDTH-1:0] payload_o;
  logic                     payload_valid_o;
  logic                     payload_ready_i;
  logic                     error_o;

  modport slave (
    input  packet_req_i, lock_i, packet_i, payload_ready_i,
    output packet_grant_o, packet_received_o, payload_o, payload_valid_o, error_o
  );

  modport master (
    output packet_req_i, lock_i, packet_i, payload_ready_i,
    input  packet_grant_o, packet_received_o, payload_o, payload_valid_o, error_o
  );

endinterface

// File: rtl/depkt_out_fifo.sv
// Single-clock first-word-fall-through FIFO, DEPTH x WIDTH.
// Ports: clk_payload, reset (async, active-high), wr_en/wr_data push,
//        rd_en pop, rd_data head entry, count/full/empty status.
// Writes when full and reads when empty are ignored.
module depkt_out_fifo #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DEPTH_LOG = 1
) (
  input  logic               clk_payload,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic [DEPTH_LOG:0] count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = DEPTH_LOG;
  localparam int unsigned CNT_W = DEPTH_LOG + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr_c;
  logic             do_rd_c;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr_c = wr_en & ~full;
  assign do_rd_c = rd_en & ~empty;

  // Pointer increment with wrap for non power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk_payload or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr_c) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_rd_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr_c, do_rd_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/depacketizer_wide.sv
// Receive side of the wide serial link. Reassembles a start/header/data
// packet stream into one PAYLOAD_WIDTH word and queues it for the consumer.
// Ports: clk_payload, reset (async, active-high), link (depacketizer_wide_if
//        slave: packet_req_i, lock_i, packet_i, packet_grant_o,
//        packet_received_o, payload_o, payload_valid_o, payload_ready_i,
//        error_o).
// Build option: DEPKT_HDR_CHECK_EN -- when defined the header must equal
// N_PKTS, otherwise the transaction is dropped and error_o is set; when
// undefined the header is ignored.
module depacketizer_wide
  import serdes_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 512,
  parameter int unsigned PACKET_WIDTH  = 16,
  parameter logic        ID            = 1'b0,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned DEPTH_LOG     = 1
) (
  input logic                 clk_payload,
  input logic                 reset,
  depacketizer_wide_if.slave  link
);

  localparam int unsigned N_DATA     = calc_n_data(PAYLOAD_WIDTH, PACKET_WIDTH);
  localparam int unsigned N_PKTS     = calc_n_pkts(PAYLOAD_WIDTH, PACKET_WIDTH);
  localparam int unsigned CNT_W      = $clog2(N_PKTS + 1) + 1;
  localparam int unsigned FIFO_CNT_W = DEPTH_LOG + 1;

  depkt_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PAYLOAD_WIDTH-1:0] asm_q, asm_d;
  logic                     received_q, received_d;
  logic                     error_q, error_d;
  logic                     grant_c;
  logic                     push_c;
  logic                     slot_free_c;

  logic [FIFO_CNT_W-1:0]    fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PAYLOAD_WIDTH-1:0] fifo_head;

  // A slot is reserved before grant, so DATA never meets a full buffer
  assign slot_free_c = (fifo_count < FIFO_CNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk_payload or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, grant, assembly and error/received updates
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    received_d = 1'b0;
    error_d    = error_q;
    grant_c    = 1'b0;
    push_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_c = link.packet_req_i & slot_free_c;
        if (grant_c) begin
          if (link.packet_i[START_VALID_BIT] && (link.packet_i[START_ID_BIT] == ID))
            state_d = ST_HDR;
          else
            error_d = 1'b1;
        end
      end

      ST_HDR: begin
        grant_c = 1'b1;
        cnt_d   = '0;
        if (!link.lock_i) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
`ifdef DEPKT_HDR_CHECK_EN
          if (link.packet_i != PACKET_WIDTH'(N_PKTS)) begin
            error_d = 1'b1;
            state_d = ST_DROP;
          end else begin
            state_d = ST_DATA;
          end
`else
          state_d = ST_DATA;
`endif
        end
      end

      ST_DATA: begin
        grant_c = 1'b1;
        if (!link.lock_i) begin
          // Partial word is abandoned; the next transaction overwrites it
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          for (int k = 0; k < int'(N_DATA); k++) begin
            if (cnt_q == CNT_W'(k)) asm_d[k*PACKET_WIDTH +: PACKET_WIDTH] = link.packet_i;
          end
          if (cnt_q == CNT_W'(N_DATA - 1)) begin
            push_c     = 1'b1;
            received_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DROP: begin
        grant_c = 1'b1;
        if (cnt_q == CNT_W'(N_DATA - 1)) state_d = ST_IDLE;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk_payload or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      received_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      received_q <= received_d;
      error_q    <= error_d;
    end
  end

  depkt_out_fifo #(
    .WIDTH     (PAYLOAD_WIDTH),
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_out_fifo (
    .clk_payload (clk_payload),
    .reset       (reset),
    .wr_en       (push_c & ~fifo_full),
    .wr_data     (asm_d),
    .rd_en       (link.payload_ready_i),
    .rd_data     (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign link.packet_grant_o    = grant_c;
  assign link.packet_received_o = received_q;
  assign link.payload_o         = fifo_head;
  assign link.payload_valid_o   = ~fifo_empty;
  assign link.error_o           = error_q;

endmodule

// File: tb/tb_depacketizer_wide.sv
// Scoreboard bench for depacketizer_wide (64-bit payload, 16-bit packets).
module tb_depacketizer_wide;

  logic clk_payload;
  logic reset;

  depacketizer_wide_if #(.PAYLOAD_WIDTH(64), .PACKET_WIDTH(16)) bus ();

  depacketizer_wide #(
    .PAYLOAD_WIDTH (64),
    .PACKET_WIDTH  (16),
    .ID            (1'b0),
    .DEPTH         (2),
    .DEPTH_LOG     (1)
  ) dut (
    .clk_payload (clk_payload),
    .reset       (reset),
    .link        (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rcv_cnt  = 0;
  int gnt_cnt  = 0;
  logic [63:0] exp_q [$];

  initial clk_payload = 1'b0;
  always #5 clk_payload = ~clk_payload;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_payload);
    #1;
  endtask

  task automatic settle();
    tick();
    @(negedge clk_payload);
  endtask

  // Scoreboard monitor: compare every popped payload with the queue head
  always @(negedge clk_payload) begin
    if (!reset && bus.payload_valid_o && bus.payload_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_pop: got %h expected none", bus.payload_o);
      end else begin
        chk("sb_payload", bus.payload_o, exp_q.pop_front());
      end
    end
  end

  // Pulse and grant-cycle counters
  always @(negedge clk_payload) begin
    if (!reset && bus.packet_received_o) rcv_cnt++;
    if (!reset && bus.packet_grant_o)    gnt_cnt++;
  end

  // Present a start packet and wait (bounded) for the grant
  task automatic start_txn(input logic [15:0] start);
    bit ok;
    ok = 1'b0;
    tick();
    bus.packet_req_i = 1'b1;
    bus.lock_i       = 1'b1;
    bus.packet_i     = start;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_payload);
      if (bus.packet_grant_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_wait", 64'(ok), 64'd1);
  endtask

  // Header and four data packets; lock falls on data index drop_at (-1: never).
  // Returns at the negedge of cycle t+6.
  task automatic body(input logic [15:0] hdr, input logic [63:0] data,
                      input int drop_at, output logic v_pre);
    tick();
    bus.packet_req_i = 1'b0;
    bus.packet_i     = hdr;
    v_pre = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.packet_i = data[k*16 +: 16];
      if (k == drop_at) bus.lock_i = 1'b0;
      if (k == 3) begin
        @(negedge clk_payload);
        v_pre = bus.payload_valid_o;
      end
    end
    tick();
    bus.packet_i = '0;
    bus.lock_i   = 1'b0;
    @(negedge clk_payload);
  endtask

  task automatic send_ok(input logic [63:0] data);
    logic v;
    start_txn(16'h0001);
    exp_q.push_back(data);
    body(16'h0005, data, -1, v);
  endtask

  task automatic pop_one();
    tick();
    bus.payload_ready_i = 1'b1;
    @(negedge clk_payload);
    chk("pop_valid", 64'(bus.payload_valid_o), 64'd1);
    tick();
    bus.payload_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    bus.packet_req_i    = 1'b0;
    bus.lock_i          = 1'b0;
    bus.packet_i        = '0;
    bus.payload_ready_i = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clk_payload);
    chk("rst_error_clear", 64'(bus.error_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v_pre;
    int   r0, g0, seen;

    reset = 1'b0;
    bus.packet_req_i    = 1'b0;
    bus.lock_i          = 1'b0;
    bus.packet_i        = '0;
    bus.payload_ready_i = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_grant",    64'(bus.packet_grant_o),    64'd0);
    chk("rst_received", 64'(bus.packet_received_o), 64'd0);
    chk("rst_valid",    64'(bus.payload_valid_o),   64'd0);
    chk("rst_payload",  bus.payload_o,              64'd0);
    chk("rst_error",    64'(bus.error_o),           64'd0);
    repeat (2) @(posedge clk_payload);
    #1 reset = 1'b0;

    // Nominal transaction
    r0 = rcv_cnt; g0 = gnt_cnt;
    start_txn(16'h0001);
    exp_q.push_back(64'h4444_3333_2222_1111);
    body(16'h0005, 64'h4444_3333_2222_1111, -1, v_pre);
    chk("nom_valid_t5",  64'(v_pre), 64'd0);
    chk("nom_valid_t6",  64'(bus.payload_valid_o), 64'd1);
    chk("nom_rcv_t6",    64'(bus.packet_received_o), 64'd1);
    chk("nom_payload",   bus.payload_o, 64'h4444_3333_2222_1111);
    settle();
    chk("nom_rcv_count", 64'(rcv_cnt - r0), 64'd1);
    chk("nom_grant_cyc", 64'(gnt_cnt - g0), 64'd6);
    chk("nom_error",     64'(bus.error_o), 64'd0);
    pop_one();
    @(negedge clk_payload);
    chk("nom_empty",     64'(bus.payload_valid_o), 64'd0);

    // Back-to-back into a full buffer, then grant after one pop
    r0 = rcv_cnt;
    send_ok(64'h0123_4567_89ab_cdef);
    send_ok(64'hfedc_ba98_7654_3210);
    settle();
    chk("b2b_rcv_count", 64'(rcv_cnt - r0), 64'd2);
    tick();
    bus.packet_req_i = 1'b1;
    bus.lock_i       = 1'b1;
    bus.packet_i     = 16'h0001;
    seen = 0;
    repeat (5) begin
      @(negedge clk_payload);
      if (bus.packet_grant_o) seen++;
    end
    chk("b2b_no_grant_full", 64'(seen), 64'd0);
    tick();
    bus.payload_ready_i = 1'b1;
    @(negedge clk_payload);
    chk("b2b_grant_at_pop", 64'(bus.packet_grant_o), 64'd0);
    tick();
    bus.payload_ready_i = 1'b0;
    @(negedge clk_payload);
    chk("b2b_grant_after_pop", 64'(bus.packet_grant_o), 64'd1);
    exp_q.push_back(64'h0f0f_f0f0_a5a5_5a5a);
    body(16'h0005, 64'h0f0f_f0f0_a5a5_5a5a, -1, v_pre);
    settle();
    pop_one();
    pop_one();
    @(negedge clk_payload);
    chk("b2b_drained", 64'(bus.payload_valid_o), 64'd0);

    // Wrong stream ID
    chk("wid_error_before", 64'(bus.error_o), 64'd0);
    start_txn(16'h0003);
    tick();
    bus.packet_req_i = 1'b0;
    bus.packet_i     = '0;
    bus.lock_i       = 1'b0;
    @(negedge clk_payload);
    chk("wid_error",   64'(bus.error_o), 64'd1);
    chk("wid_no_push", 64'(bus.payload_valid_o), 64'd0);
    r0 = rcv_cnt;
    send_ok(64'h1357_9bdf_2468_ace0);
    settle();
    chk("wid_recover_valid", 64'(bus.payload_valid_o), 64'd1);
    chk("wid_recover_rcv",   64'(rcv_cnt - r0), 64'd1);
    pop_one();

    do_reset();

    // Lock drop after two data packets with one entry already buffered
    send_ok(64'haaaa_bbbb_cccc_dddd);
    settle();
    r0 = rcv_cnt;
    start_txn(16'h0001);
    body(16'h0005, 64'h9999_8888_7777_6666, 2, v_pre);
    chk("lock_error", 64'(bus.error_o), 64'd1);
    settle();
    chk("lock_no_rcv", 64'(rcv_cnt - r0), 64'd0);
    pop_one();
    @(negedge clk_payload);
    chk("lock_count_unchanged", 64'(bus.payload_valid_o), 64'd0);

    do_reset();

    // Header value 4 instead of 5
    r0 = rcv_cnt; g0 = gnt_cnt;
    start_txn(16'h0001);
`ifdef DEPKT_HDR_CHECK_EN
    body(16'h0004, 64'hdead_beef_cafe_f00d, -1, v_pre);
    chk("bhdr_error", 64'(bus.error_o), 64'd1);
    settle();
    chk("bhdr_grant_cyc", 64'(gnt_cnt - g0), 64'd6);
    chk("bhdr_no_rcv",    64'(rcv_cnt - r0), 64'd0);
    chk("bhdr_no_push",   64'(bus.payload_valid_o), 64'd0);
`else
    exp_q.push_back(64'hdead_beef_cafe_f00d);
    body(16'h0004, 64'hdead_beef_cafe_f00d, -1, v_pre);
    chk("bhdr_ignored_error", 64'(bus.error_o), 64'd0);
    settle();
    chk("bhdr_grant_cyc", 64'(gnt_cnt - g0), 64'd6);
    chk("bhdr_rcv",       64'(rcv_cnt - r0), 64'd1);
    chk("bhdr_push",      64'(bus.payload_valid_o), 64'd1);
    pop_one();
`endif

    // Reset in the middle of a transaction with one entry buffered
    send_ok(64'h7777_6666_5555_4444);
    settle();
    start_txn(16'h0001);
    tick();
    bus.packet_req_i = 1'b0;
    bus.packet_i     = 16'h0005;
    tick();
    bus.packet_i = 16'h0101;
    tick();
    bus.packet_i = 16'h0202;
    tick();
    bus.packet_i = 16'h0303;
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_grant",    64'(bus.packet_grant_o),    64'd0);
    chk("mid_rst_received", 64'(bus.packet_received_o), 64'd0);
    chk("mid_rst_valid",    64'(bus.payload_valid_o),   64'd0);
    chk("mid_rst_payload",  bus.payload_o,              64'd0);
    chk("mid_rst_error",    64'(bus.error_o),           64'd0);
    tick();
    reset        = 1'b0;
    bus.lock_i   = 1'b0;
    bus.packet_i = '0;
    r0 = rcv_cnt;
    send_ok(64'h0bad_f00d_1234_5678);
    settle();
    chk("post_rst_valid", 64'(bus.payload_valid_o), 64'd1);
    chk("post_rst_rcv",   64'(rcv_cnt - r0), 64'd1);
    pop_one();
    settle();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/depacketizer_wide.md
# depacketizer_wide

Receive side of the wide serial link. Accepts the start/header/data packet stream produced by the wide packetizer, reassembles it into one PAYLOAD_WIDTH word and queues it in a small output buffer for the cache/L2 consumer. It issues the link grant only when a complete payload can be absorbed, and it returns a per-transaction completion pulse that feeds the sender's throttle counter.

## Interface
- PAYLOAD_WIDTH, 512: width of the reassembled payload; must be a multiple of PACKET_WIDTH.
- PACKET_WIDTH, 16: link packet width; must be at least N_PKTS_LOG+1 bits.
- ID, 0: 1-bit stream ID this receiver accepts.
- DEPTH, 2: number of output buffer entries.
- DEPTH_LOG, 1: log2(DEPTH).
- clk_payload  input  1  single clock for the block; the packet link is already synchronous to it.
- reset  input  1  asynchronous, active-high.
- packet_req_i  input  1  sender has a transaction pending.
- lock_i  input  1  sender holds the link; only monitored.
- packet_i  input  PACKET_WIDTH  packet stream.
- packet_grant_o  output  1  link grant, held for the whole transaction.
- packet_received_o  output  1  one-cycle pulse when a transaction completes.
- payload_o  output  PAYLOAD_WIDTH  head-of-buffer payload.
- payload_valid_o  output  1  the buffer is non-empty.
- payload_ready_i  input  1  consumer pop; the pop happens when this and payload_valid_o are both high.
- error_o  output  1  sticky protocol error flag.

## Operation
- Derived constants:
  - N_DATA = PAYLOAD_WIDTH/PACKET_WIDTH.
  - N_PKTS = N_DATA+1, which is the header value.
  - Counter width is clog2(N_PKTS+1)+1.
- The FSM has four states: IDLE, HDR, DATA, DROP.
- IDLE:
  - packet_grant_o = packet_req_i & (count < DEPTH).
  - In a grant cycle, packet_i is the start packet.
  - If bit0==1 and bit1==ID, go to HDR.
  - Otherwise set error_o and stay in IDLE.
- HDR:
  - Grant is held.
  - Header is checked (see Configuration).
  - On pass, clear the data counter and go to DATA.
  - On fail, go to DROP.
- DATA:
  - Grant is held. Each cycle, the k-th data packet (k=0 first) is written to assembly bits [k*PACKET_WIDTH +: PACKET_WIDTH]. The first packet is the LSB.
  - After packet k=N_DATA-1 is captured, the assembled word is pushed to the buffer, packet_received_o pulses, grant drops and the FSM goes to IDLE.
- DROP:
  - Consumes N_DATA cycles with grant held, then returns to IDLE.
  - Nothing is pushed and no received pulse is issued.
- There is no mid-transaction backpressure. The sender pops every cycle once started, so a buffer slot is reserved before grant. Buffer full therefore cannot occur in DATA.
- A push and a pop in the same cycle leave count unchanged.
- Buffer empty: payload_valid_o=0. payload_o is don't-care but holds the last head.
- lock_i deasserting in HDR or DATA sets error_o and forces IDLE. The partial word is discarded.

## Timing
- Reset values: packet_grant_o=0, packet_received_o=0, payload_valid_o=0, payload_o=0, error_o=0, FSM=IDLE, buffer empty.
- Let t be the first grant cycle, in which the start packet is on packet_i.
  - Header is at t+1.
  - Data runs t+2 .. t+N_DATA+1.
  - Grant is high t .. t+N_DATA+1.
  - Push and packet_received_o occur at t+N_DATA+2.
  - payload_valid_o rises at t+N_DATA+2 when the buffer was empty.
- Next grant is possible at t+N_DATA+2, if a slot is free at that cycle's count.
- Pop to slot freed: 1 cycle. Grant can re-assert the cycle after the pop.
- Reset mid-transaction: asynchronous return to the reset state; buffered payloads are lost.

## Configuration
- DEPKT_HDR_CHECK_EN defined:
  - The header value must equal N_PKTS.
  - A mismatch sets error_o and the FSM enters DROP.
- DEPKT_HDR_CHECK_EN undefined:
  - The header is ignored; HDR always proceeds to DATA.
  - error_o is driven only by start-packet and lock errors.

## Structure
- The shared package serdes_pkg holds:
  - the FSM state enum;
  - the N_PKTS/N_DATA derivation function;
  - the start-packet field positions (valid bit 0, ID bit 1).
- One sub-module, depkt_out_fifo, is a single-clock DEPTH x PAYLOAD_WIDTH FWFT FIFO. It exports count, full and empty.

## Test plan
All scenarios use PAYLOAD_WIDTH=64, PACKET_WIDTH=16, ID=0.
- Nominal: send start 16'h0001, header 16'h0005, then data 1111, 2222, 3333, 4444.
  - Expect payload_o=64'h4444_3333_2222_1111 and valid at t+6.
  - Expect a single packet_received_o pulse.
- Back-to-back: two transactions with payload_ready_i=0.
  - Both are accepted.
  - A third packet_req_i gets no grant until one pop; grant follows 1 cycle after that pop.
- Bad header with DEPKT_HDR_CHECK_EN defined: header 16'h0004.
  - Expect error_o=1, no push, no received pulse.
  - Grant is held 6 cycles, then the FSM returns to IDLE.
- Wrong ID: start 16'h0003.
  - Expect error_o=1 and the FSM stays in IDLE.
  - A following correct start completes normally.
- Lock drop: lock_i falls after 2 data packets.
  - Expect error_o=1 and the partial word discarded.
  - The buffer count is unchanged.
- Reset: assert reset after 2 data packets.
  - All outputs go to 0 immediately.
  - A subsequent full transaction completes normally.
